// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter that shares one line-wide memory port between an I-cache (r0)
// and a D-cache (r1). Grant, issue, wait and response run as a four-state FSM.
module cache_bus_arbiter #(
   parameter int ADDR_WIDTH       = 64,
   parameter int DATA_WIDTH       = 64,
   parameter int OFFSET_LENGTH    = 4,
   parameter int CROSS_INVALIDATE = 1,
   localparam int LINE_WIDTH      = DATA_WIDTH * (2 ** OFFSET_LENGTH)
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  r0_command_valid,
   input  logic                  r0_command_store,
   input  logic                  r0_command_rready,
   input  logic [ADDR_WIDTH-1:0] r0_command_addr,
   input  logic [LINE_WIDTH-1:0] r0_data_to_bus,
   output logic [LINE_WIDTH-1:0] r0_data_from_bus,
   output logic                  r0_bus_valid,
   output logic                  r0_bus_ready,
   output logic                  r0_invalidate,
   output logic [ADDR_WIDTH-1:0] r0_invalidate_addr,

   input  logic                  r1_command_valid,
   input  logic                  r1_command_store,
   input  logic                  r1_command_rready,
   input  logic [ADDR_WIDTH-1:0] r1_command_addr,
   input  logic [LINE_WIDTH-1:0] r1_data_to_bus,
   output logic [LINE_WIDTH-1:0] r1_data_from_bus,
   output logic                  r1_bus_valid,
   output logic                  r1_bus_ready,
   output logic                  r1_invalidate,
   output logic [ADDR_WIDTH-1:0] r1_invalidate_addr,

   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic                  mem_cmd_store,
   output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp_valid,
   input  logic [LINE_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH-OFFSET_LENGTH){1'b1}}, {OFFSET_LENGTH{1'b0}}};

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic                  store_q, store_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  cmd_valid_q, cmd_valid_d;
   logic [1:0]            bus_valid_q, bus_valid_d;
   logic [1:0]            bus_ready_q, bus_ready_d;
   logic [1:0]            inval_q, inval_d;
   logic [ADDR_WIDTH-1:0] inval_addr0_q, inval_addr0_d;
   logic [ADDR_WIDTH-1:0] inval_addr1_q, inval_addr1_d;
   logic [LINE_WIDTH-1:0] data0_q, data0_d;
   logic [LINE_WIDTH-1:0] data1_q, data1_d;
   logic                  pick;

   // Fill-ready from the caches is informational only; the arbiter never waits on it.
   logic unused_rready;
   assign unused_rready = r0_command_rready ^ r1_command_rready;

   // On a tie the requester that did not win last time gets the bus.
   always_comb begin
      pick = r1_command_valid;
      if (r0_command_valid && r1_command_valid) begin
         pick = ~last_grant_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      store_d       = store_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      cmd_valid_d   = cmd_valid_q;
      bus_valid_d   = 2'b00;
      bus_ready_d   = 2'b00;
      inval_d       = 2'b00;
      inval_addr0_d = inval_addr0_q;
      inval_addr1_d = inval_addr1_q;
      data0_d       = data0_q;
      data1_d       = data1_q;

      case (state_q)
         S_IDLE: begin
            if (r0_command_valid || r1_command_valid) begin
               grant_d      = pick;
               last_grant_d = pick;
               store_d      = pick ? r1_command_store : r0_command_store;
               addr_d       = (pick ? r1_command_addr : r0_command_addr) & LINE_MASK;
               wdata_d      = pick ? r1_data_to_bus : r0_data_to_bus;
               cmd_valid_d  = 1'b1;
               state_d      = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (mem_cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = S_WAIT;
               // A writeback makes any copy of the line in the other cache stale.
               if (store_q && (CROSS_INVALIDATE != 0)) begin
                  if (grant_q) begin
                     inval_d[0]    = 1'b1;
                     inval_addr0_d = addr_q;
                  end else begin
                     inval_d[1]    = 1'b1;
                     inval_addr1_d = addr_q;
                  end
               end
            end
         end

         S_WAIT: begin
            if (mem_resp_valid) begin
               state_d = S_RESP;
               if (store_q) begin
                  bus_ready_d[grant_q] = 1'b1;
               end else begin
                  bus_valid_d[grant_q] = 1'b1;
                  if (grant_q) begin
                     data1_d = mem_rdata;
                  end else begin
                     data0_d = mem_rdata;
                  end
               end
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         store_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cmd_valid_q   <= 1'b0;
         bus_valid_q   <= 2'b00;
         bus_ready_q   <= 2'b00;
         inval_q       <= 2'b00;
         inval_addr0_q <= '0;
         inval_addr1_q <= '0;
         data0_q       <= '0;
         data1_q       <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         store_q       <= store_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cmd_valid_q   <= cmd_valid_d;
         bus_valid_q   <= bus_valid_d;
         bus_ready_q   <= bus_ready_d;
         inval_q       <= inval_d;
         inval_addr0_q <= inval_addr0_d;
         inval_addr1_q <= inval_addr1_d;
         data0_q       <= data0_d;
         data1_q       <= data1_d;
      end
   end

   assign mem_cmd_valid      = cmd_valid_q;
   assign mem_cmd_store      = store_q;
   assign mem_cmd_addr       = addr_q;
   assign mem_wdata          = wdata_q;

   assign r0_data_from_bus   = data0_q;
   assign r0_bus_valid       = bus_valid_q[0];
   assign r0_bus_ready       = bus_ready_q[0];
   assign r0_invalidate      = inval_q[0];
   assign r0_invalidate_addr = inval_addr0_q;

   assign r1_data_from_bus   = data1_q;
   assign r1_bus_valid       = bus_valid_q[1];
   assign r1_bus_ready       = bus_ready_q[1];
   assign r1_invalidate      = inval_q[1];
   assign r1_invalidate_addr = inval_addr1_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: loads, round-robin ties, writebacks with and
// without cross-invalidate, command backpressure and reset during an outstanding load.
module tb_cache_bus_arbiter;

   localparam int AW = 64;
   localparam int DW = 8;
   localparam int OL = 4;
   localparam int LW = DW * (2 ** OL);

   logic          clk = 1'b0;
   logic          reset;

   logic          r0_command_valid, r0_command_store, r0_command_rready;
   logic [AW-1:0] r0_command_addr;
   logic [LW-1:0] r0_data_to_bus;
   logic [LW-1:0] r0_data_from_bus;
   logic          r0_bus_valid, r0_bus_ready, r0_invalidate;
   logic [AW-1:0] r0_invalidate_addr;

   logic          r1_command_valid, r1_command_store, r1_command_rready;
   logic [AW-1:0] r1_command_addr;
   logic [LW-1:0] r1_data_to_bus;
   logic [LW-1:0] r1_data_from_bus;
   logic          r1_bus_valid, r1_bus_ready, r1_invalidate;
   logic [AW-1:0] r1_invalidate_addr;

   logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_store;
   logic [AW-1:0] mem_cmd_addr;
   logic [LW-1:0] mem_wdata;
   logic          mem_resp_valid;
   logic [LW-1:0] mem_rdata;

   // Outputs of the instance built without cross-invalidate.
   logic [LW-1:0] ni_r0_data_from_bus, ni_r1_data_from_bus;
   logic          ni_r0_bus_valid, ni_r0_bus_ready, ni_r0_invalidate;
   logic          ni_r1_bus_valid, ni_r1_bus_ready, ni_r1_invalidate;
   logic [AW-1:0] ni_r0_invalidate_addr, ni_r1_invalidate_addr;
   logic          ni_mem_cmd_valid, ni_mem_cmd_store;
   logic [AW-1:0] ni_mem_cmd_addr;
   logic [LW-1:0] ni_mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [LW-1:0] LINE_A = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
   localparam logic [LW-1:0] LINE_B = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
   localparam logic [LW-1:0] LINE_C0 = 128'hC0C0_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [LW-1:0] LINE_C1 = 128'hC1C1_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
   localparam logic [LW-1:0] LINE_D = 128'hD00D_F00D_0123_4567_89AB_CDEF_FEDC_BA98;
   localparam logic [LW-1:0] LINE_E = 128'hE1E2_E3E4_E5E6_E7E8_E9EA_EBEC_EDEE_EFF0;

   cache_bus_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL), .CROSS_INVALIDATE(1)
   ) dut (
      .clk(clk), .reset(reset),
      .r0_command_valid(r0_command_valid), .r0_command_store(r0_command_store),
      .r0_command_rready(r0_command_rready), .r0_command_addr(r0_command_addr),
      .r0_data_to_bus(r0_data_to_bus), .r0_data_from_bus(r0_data_from_bus),
      .r0_bus_valid(r0_bus_valid), .r0_bus_ready(r0_bus_ready),
      .r0_invalidate(r0_invalidate), .r0_invalidate_addr(r0_invalidate_addr),
      .r1_command_valid(r1_command_valid), .r1_command_store(r1_command_store),
      .r1_command_rready(r1_command_rready), .r1_command_addr(r1_command_addr),
      .r1_data_to_bus(r1_data_to_bus), .r1_data_from_bus(r1_data_from_bus),
      .r1_bus_valid(r1_bus_valid), .r1_bus_ready(r1_bus_ready),
      .r1_invalidate(r1_invalidate), .r1_invalidate_addr(r1_invalidate_addr),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_store(mem_cmd_store), .mem_cmd_addr(mem_cmd_addr),
      .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   cache_bus_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL), .CROSS_INVALIDATE(0)
   ) dut_ni (
      .clk(clk), .reset(reset),
      .r0_command_valid(r0_command_valid), .r0_command_store(r0_command_store),
      .r0_command_rready(r0_command_rready), .r0_command_addr(r0_command_addr),
      .r0_data_to_bus(r0_data_to_bus), .r0_data_from_bus(ni_r0_data_from_bus),
      .r0_bus_valid(ni_r0_bus_valid), .r0_bus_ready(ni_r0_bus_ready),
      .r0_invalidate(ni_r0_invalidate), .r0_invalidate_addr(ni_r0_invalidate_addr),
      .r1_command_valid(r1_command_valid), .r1_command_store(r1_command_store),
      .r1_command_rready(r1_command_rready), .r1_command_addr(r1_command_addr),
      .r1_data_to_bus(r1_data_to_bus), .r1_data_from_bus(ni_r1_data_from_bus),
      .r1_bus_valid(ni_r1_bus_valid), .r1_bus_ready(ni_r1_bus_ready),
      .r1_invalidate(ni_r1_invalidate), .r1_invalidate_addr(ni_r1_invalidate_addr),
      .mem_cmd_valid(ni_mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_store(ni_mem_cmd_store), .mem_cmd_addr(ni_mem_cmd_addr),
      .mem_wdata(ni_mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [LW-1:0] got,
                            input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serves one load with same-cycle command ready and immediate response.
   task automatic serve_load(input int g, input logic [AW-1:0] a, input logic [LW-1:0] d);
      tick();
      check_val("rr_cmd_valid", mem_cmd_valid, 1);
      check_val("rr_cmd_addr", mem_cmd_addr, a);
      check_val("rr_cmd_store", mem_cmd_store, 0);
      tick();
      check_val("rr_cmd_drop", mem_cmd_valid, 0);
      mem_resp_valid = 1'b1;
      mem_rdata      = d;
      tick();
      check_val("rr_pulse", (g == 0) ? r0_bus_valid : r1_bus_valid, 1);
      check_val("rr_other", (g == 0) ? r1_bus_valid : r0_bus_valid, 0);
      check_val("rr_data", (g == 0) ? r0_data_from_bus : r1_data_from_bus, d);
      mem_resp_valid = 1'b0;
      tick();
      check_val("rr_pulse_end", {r0_bus_valid, r1_bus_valid}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      r0_command_valid = 0; r0_command_store = 0; r0_command_rready = 1;
      r0_command_addr = '0; r0_data_to_bus = '0;
      r1_command_valid = 0; r1_command_store = 0; r1_command_rready = 1;
      r1_command_addr = '0; r1_data_to_bus = '0;
      mem_cmd_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
      tick();
      tick();
      reset = 1'b0;
      check_val("rst_cmd_valid", mem_cmd_valid, 0);
      check_val("rst_cmd_addr", mem_cmd_addr, 0);
      check_val("rst_pulses", {r0_bus_valid, r0_bus_ready, r1_bus_valid, r1_bus_ready}, 0);
      check_val("rst_inval", {r0_invalidate, r1_invalidate}, 0);
      check_val("rst_data0", r0_data_from_bus, 0);

      // Single load from r0, response three cycles after the command is accepted.
      r0_command_valid = 1; r0_command_addr = 64'h1234;
      tick();
      check_val("ld_cmd_valid", mem_cmd_valid, 1);
      check_val("ld_cmd_addr", mem_cmd_addr, 64'h1230);
      check_val("ld_cmd_store", mem_cmd_store, 0);
      mem_cmd_ready = 1;
      tick();
      check_val("ld_wait_valid", mem_cmd_valid, 0);
      mem_cmd_ready = 0;
      tick();
      tick();
      check_val("ld_no_early", r0_bus_valid, 0);
      mem_resp_valid = 1; mem_rdata = LINE_A;
      tick();
      check_val("ld_pulse", r0_bus_valid, 1);
      check_val("ld_data", r0_data_from_bus, LINE_A);
      check_val("ld_r1_quiet", {r1_bus_valid, r1_bus_ready, r1_invalidate}, 0);
      check_val("ld_r1_data", r1_data_from_bus, 0);
      mem_resp_valid = 0; r0_command_valid = 0;
      tick();
      check_val("ld_pulse_end", r0_bus_valid, 0);
      check_val("ld_data_hold", r0_data_from_bus, LINE_A);

      // Reset again so both caches request from a fresh last-grant.
      reset = 1;
      tick();
      reset = 0;
      check_val("rst2_data0", r0_data_from_bus, 0);

      // Both held: grants must alternate 0,1,0,1.
      r0_command_valid = 1; r0_command_addr = 64'h100;
      r1_command_valid = 1; r1_command_addr = 64'h200;
      mem_cmd_ready = 1;
      serve_load(0, 64'h100, LINE_C0);
      serve_load(1, 64'h200, LINE_C1);
      serve_load(0, 64'h100, LINE_C1);
      serve_load(1, 64'h200, LINE_C0);
      r0_command_valid = 0; r1_command_valid = 0;

      // Writeback from r1 with cross-invalidate toward r0.
      r1_command_valid = 1; r1_command_store = 1; r1_command_addr = 64'h8040;
      r1_data_to_bus = LINE_B;
      tick();
      check_val("wb_cmd_valid", mem_cmd_valid, 1);
      check_val("wb_cmd_store", mem_cmd_store, 1);
      check_val("wb_cmd_addr", mem_cmd_addr, 64'h8040);
      check_val("wb_wdata", mem_wdata, LINE_B);
      tick();
      check_val("wb_inval", r0_invalidate, 1);
      check_val("wb_inval_addr", r0_invalidate_addr, 64'h8040);
      check_val("wb_inval_self", r1_invalidate, 0);
      check_val("wb_ni_inval", {ni_r0_invalidate, ni_r1_invalidate}, 0);
      tick();
      check_val("wb_inval_end", r0_invalidate, 0);
      mem_resp_valid = 1;
      tick();
      check_val("wb_ready", r1_bus_ready, 1);
      check_val("wb_no_valid", r1_bus_valid, 0);
      check_val("wb_ni_ready", ni_r1_bus_ready, 1);
      mem_resp_valid = 0; r1_command_valid = 0; r1_command_store = 0;
      tick();
      check_val("wb_ready_end", r1_bus_ready, 0);

      // r0 writeback stalled by mem_cmd_ready, with a spurious response and changing inputs.
      mem_cmd_ready = 0;
      r0_command_valid = 1; r0_command_store = 1; r0_command_addr = 64'h40F7;
      r0_data_to_bus = LINE_D;
      tick();
      check_val("bp_grant_addr", mem_cmd_addr, 64'h40F0);
      r0_command_addr = 64'hFFFF_0000; r0_data_to_bus = '0; mem_resp_valid = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("bp_hold_valid", mem_cmd_valid, 1);
         check_val("bp_hold_addr", mem_cmd_addr, 64'h40F0);
         check_val("bp_hold_wdata", mem_wdata, LINE_D);
         check_val("bp_hold_store", mem_cmd_store, 1);
         check_val("bp_no_resp", r0_bus_ready, 0);
      end
      mem_resp_valid = 0; mem_cmd_ready = 1;
      tick();
      check_val("bp_issue_done", mem_cmd_valid, 0);
      check_val("bp_inval_r1", r1_invalidate, 1);
      check_val("bp_inval_addr", r1_invalidate_addr, 64'h40F0);
      mem_cmd_ready = 0; r0_command_valid = 0; r0_command_store = 0;
      mem_resp_valid = 1;
      tick();
      check_val("bp_drop_ready", r0_bus_ready, 1);
      mem_resp_valid = 0;
      tick();
      check_val("bp_ready_end", r0_bus_ready, 0);

      // Reset while r1's load waits for memory; the late response must be dropped.
      r1_command_valid = 1; r1_command_addr = 64'h300; mem_cmd_ready = 1;
      tick();
      check_val("rw_grant_addr", mem_cmd_addr, 64'h300);
      tick();
      reset = 1;
      tick();
      check_val("rw_cleared_addr", mem_cmd_addr, 0);
      reset = 0; r1_command_valid = 0; mem_resp_valid = 1; mem_rdata = LINE_D;
      tick();
      check_val("rw_no_pulse", {r1_bus_valid, r1_bus_ready, mem_cmd_valid}, 0);
      tick();
      check_val("rw_no_pulse2", {r1_bus_valid, r1_bus_ready}, 0);
      check_val("rw_no_data", r1_data_from_bus, 0);
      mem_resp_valid = 0;
      r0_command_valid = 1; r0_command_addr = 64'h500;
      r1_command_valid = 1; r1_command_addr = 64'h600;
      serve_load(0, 64'h500, LINE_E);
      r0_command_valid = 0; r1_command_valid = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares one line-wide memory port between two direct-mapped caches: requester 0 is the I-cache, requester 1 is the D-cache.
- Grants one cache command at a time using round-robin arbitration.
- Sequences the grant through issue, wait and response, and returns a one-cycle completion pulse (bus_valid for loads, bus_ready for stores).
- Optionally pulses invalidate to the other cache when a line is written back, keeping I/D copies coherent.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, cache word width.
- OFFSET_LENGTH, 4, log2 words per line; LINE_WIDTH = DATA_WIDTH*2**OFFSET_LENGTH.
- CROSS_INVALIDATE, 1, 1 = a store from one requester invalidates the same line in the other.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rN_command_valid  in  1  request from cache N (N=0,1); held until completion.
- rN_command_store  in  1  1 = line writeback, 0 = line fill.
- rN_command_rready  in  1  fill requester ready (informational, not gating).
- rN_command_addr  in  ADDR_WIDTH  line address.
- rN_data_to_bus  in  LINE_WIDTH  writeback line.
- rN_data_from_bus  out  LINE_WIDTH  fill data.
- rN_bus_valid  out  1  fill complete pulse.
- rN_bus_ready  out  1  writeback complete pulse.
- rN_invalidate  out  1  invalidate pulse to cache N.
- rN_invalidate_addr  out  ADDR_WIDTH  line to invalidate.
- mem_cmd_valid  out  1  memory command valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_store  out  1  store/load.
- mem_cmd_addr  out  ADDR_WIDTH  line-aligned address.
- mem_wdata  out  LINE_WIDTH  store line.
- mem_resp_valid  in  1  memory completion (load data or store ack).
- mem_rdata  in  LINE_WIDTH  load line.

Behaviour:
- All outputs are registered.
- Reset:
  - state=IDLE, last_grant=1 (r0 wins the first tie).
  - All valid/ready/invalidate outputs 0; data and address outputs 0.
- States:
  - IDLE: sample both command_valid. If one is high, grant it. If both are high, grant the one not equal to last_grant. Latch store, addr (low OFFSET_LENGTH bits forced 0) and wdata. Set last_grant. Next state ISSUE.
  - ISSUE: mem_cmd_valid=1. Command fields stay stable until mem_cmd_ready. On the ready cycle, go to WAIT. If the granted command is a store and CROSS_INVALIDATE=1, pulse the other requester's invalidate for exactly that cycle+1 (registered), carrying the latched address.
  - WAIT: mem_cmd_valid=0. On mem_resp_valid, capture mem_rdata for loads and go to RESP.
  - RESP: exactly one cycle. The granted requester sees bus_valid=1 (load, data_from_bus=captured line) or bus_ready=1 (store). Next state IDLE.
- Latency: minimum 4 cycles from command_valid to completion pulse (grant, issue with same-cycle ready, response, pulse).
- mem_resp_valid in IDLE/ISSUE/RESP is ignored (no state change).
- Non-granted requester: outputs stay 0; its command stays pending and is granted in the next IDLE.
- Dropping: if the granted requester drops command_valid mid-transaction, the transaction still completes and the pulse is still issued.
- data_from_bus: holds the last captured line between pulses; the cache only samples it when bus_valid=1.
- Back-to-back: request visible in the IDLE cycle after RESP is granted immediately; no idle gap beyond the IDLE cycle.
- Reset mid-transaction: return to IDLE the next edge, all pulses cleared, the in-flight memory response is dropped.

Test Plan:
- Single load: r0 load addr 0x1234 → mem_cmd_addr=0x1230, store=0; mem_rdata=pattern A5… after 3 cycles → r0_bus_valid high exactly 1 cycle with r0_data_from_bus=pattern; r1 outputs all 0.
- Simultaneous requests: r0 and r1 both valid from reset → r0 granted first, r1 granted in the IDLE after r0's pulse; repeat with both held → grants alternate 0,1,0,1.
- Writeback with cross-invalidate: r1 store addr 0x8040, wdata=line B → mem_wdata=B, store=1; r0_invalidate pulses 1 cycle with addr 0x8040; r1_bus_ready pulses on ack. With CROSS_INVALIDATE=0, no invalidate pulse.
- Backpressure: mem_cmd_ready low 5 cycles → mem_cmd_valid and fields held constant throughout; spurious mem_resp_valid during ISSUE ignored.
- Reset mid-WAIT: assert reset during WAIT, then mem_resp_valid → no bus_valid/bus_ready pulse; next request proceeds normally from IDLE with r0 priority.
